axi_master: RTL
===============

Name: axi_master

Overview:
AXI initiator that turns single commands from a local command port into one INCR burst on the AXI bus. A command is either a write (address, data, response) or a read (address, data). The block is the counterpart of axi_slave and connects to the same axi_intf signal set. One transaction is outstanding at a time. Completion status is returned on a done port.

Parameters:
ADDR_WIDTH, 32, address width for cmd_addr, awaddr, araddr
DATA_WIDTH, 32, data bus width; must be a power of two, 8..1024
ID_WIDTH, 4, width of the transaction ID (cmd_id, awid, wid, bid, arid, rid, done_id)

Ports:
aclk  in  1  clock; all logic on rising edge
arst  in  1  reset; asynchronous, active-low
cmd_valid, cmd_ready  in/out  1  command handshake
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_id  in  ID_WIDTH  transaction ID
cmd_addr  in  ADDR_WIDTH  start address; must be aligned to DATA_WIDTH/8 (caller guarantees)
cmd_len  in  8  beats minus one
wd_valid, wd_ready  in/out  1  write-data stream handshake; wd_data in DATA_WIDTH
rd_valid, rd_ready  out/in  1  read-data stream handshake
rd_data  out  DATA_WIDTH  read data
rd_last  out  1  last beat of the read burst
done_valid  out  1  one-cycle completion pulse
done_resp  out  2  final response code
done_id  out  ID_WIDTH  ID of the completed command
awid, awaddr, awlen, awsize, awburst, awvalid  out  write-address channel; awready in
wid, wdata, wstrb, wlast, wvalid  out  write-data channel; wready in
bid, bresp, bvalid  in  write-response channel; bready out
arid, araddr, arlen, arsize, arburst, arvalid  out  read-address channel; arready in
rid, rdata, rresp, rlast, rvalid  in  read-data channel; rready out

Behaviour:
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
- Reset (arst=0, async), all outputs 0:
  - all valids, readies, done_valid, done_resp, done_id, address/len fields.
  - State goes to IDLE.
- Constant fields:
  - awsize = arsize = log2(DATA_WIDTH/8).
  - awburst = arburst = 2'b01.
  - wstrb is all ones.
  - wid = awid.
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - On cmd_valid, register id/addr/len/write.
  - 4KB check: if addr[11:0] + (len+1)*DATA_WIDTH/8 > 4096, go to DONE with resp 2'b10 and issue no bus activity.
  - Otherwise go to WADDR or RADDR.
- WADDR / RADDR:
  - awvalid / arvalid = 1 from the cycle after acceptance.
  - Fields stay stable until awready / arready is seen on a rising edge.
  - After the handshake, go to WDATA / RDATA next cycle.
- WDATA, combinational pass-through:
  - wvalid = wd_valid, wdata = wd_data, wd_ready = wready.
  - Beat counter increments per wvalid&&wready.
  - wlast = (count == len).
  - After the last handshake, go to WRESP.
  - W is never driven before the AW handshake completes.
- WRESP:
  - bready = 1.
  - On bvalid, capture resp = bresp; if bid != id, resp = 2'b10 unless bresp is already 2'b11.
  - Go to DONE.
- RDATA, combinational pass-through:
  - rd_valid = rvalid, rd_data = rdata, rd_last = rlast, rready = rd_ready.
  - Per-beat response: a beat with rid != id counts as 2'b10.
  - Accumulated resp = maximum of all per-beat codes (00 < 10 < 11); the first non-OKAY code does not stop the burst.
  - rlast on a handshake goes to DONE.
  - rlast arriving with count != len forces resp 2'b10.
- DONE:
  - done_valid = 1 for exactly one cycle with done_resp and done_id.
  - Next state is IDLE; cmd_ready rises the cycle after DONE.
- Latency: best case for a write with len=0 and all slave readies high is command accept at T, AW at T+1, W at T+2, B at T+3, done at T+4.
- Reset mid-burst aborts immediately: no done pulse, and outstanding slave state is the bench's responsibility.
- len = 255 wraps the 8-bit counter correctly; the counter width is 8 and compares equal at 255.

Test Plan:
- Write addr 0x100, len 0, data 0xDEADBEEF, slave always ready:
  - awaddr = 0x100, awlen = 0, wlast = 1 on the single beat.
  - done_valid at T+4 with resp 00.
- Write len 3, wready low on alternate cycles:
  - 4 beats in order, wlast only on beat 4.
  - No W beat before the AW handshake; bresp 00 gives done_resp 00.
- Read addr 0x200, len 3; slave returns rresp 00, 10, 00, 00:
  - rd_data passes through with rd_last on beat 4.
  - done_resp = 10.
- Read addr 0xFF8, len 3 (crosses 4KB):
  - No arvalid ever.
  - done_valid with resp 10 two cycles after acceptance.
- Read with bench rid = cmd_id+1 on beat 1, otherwise OKAY: done_resp = 10.
- arst low during WDATA beat 2: all outputs 0 immediately; the next command after release completes normally.

Source files
------------

// File: rtl/axi_master.sv
// axi_master: turns one local command into a single AXI INCR burst.
// Only one transaction is in flight; completion is reported on the done port.
// The 4KB-boundary check runs on the registered command during the address
// state, so a rejected command costs one silent cycle and never reaches the bus.
module axi_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    aclk,
    input  logic                    arst,

    // command port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,

    // write-data stream
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,

    // read-data stream
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,

    // completion
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    output logic [ID_WIDTH-1:0]     done_id,

    // AXI write address
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,

    // AXI write data
    output logic [ID_WIDTH-1:0]     wid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,

    // AXI write response
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,

    // AXI read address
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,

    // AXI read data
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int         STRB_W  = DATA_WIDTH / 8;
    localparam int         SIZE_LG = $clog2(STRB_W);
    localparam logic [2:0] AXSIZE  = 3'(SIZE_LG);
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;
    localparam logic [1:0] DECERR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [1:0]              resp_q, resp_d;

    logic [16:0]             beats_ext;
    logic [16:0]             burst_bytes;
    logic [16:0]             page_end;
    logic                    page_cross;
    logic [1:0]              beat_resp;
    logic [1:0]              acc_resp;

    // Severity order of response codes: OKAY/EXOKAY < SLVERR < DECERR.
    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] ra;
        logic [1:0] rb;
        ra = (a == DECERR) ? 2'd3 : (a == SLVERR) ? 2'd2 : 2'd0;
        rb = (b == DECERR) ? 2'd3 : (b == SLVERR) ? 2'd2 : 2'd0;
        return (rb > ra) ? b : a;
    endfunction

    // Burst byte span and 4KB page crossing of the registered command.
    assign beats_ext   = {9'd0, len_q} + 17'd1;
    assign burst_bytes = beats_ext << SIZE_LG;
    assign page_end    = {5'd0, addr_q[11:0]} + burst_bytes;
    assign page_cross  = (page_end > 17'd4096);

    // Address-channel fields come straight from the captured command.
    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = AXSIZE;
    assign awburst = 2'b01;
    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = AXSIZE;
    assign arburst = 2'b01;
    assign wid     = id_q;
    assign wstrb   = '1;

    // State and command registers; reset aborts any burst in progress.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= OKAY;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    // Next-state logic and all handshake/pass-through outputs.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        resp_d     = resp_q;
        beat_resp  = OKAY;
        acc_resp   = resp_q;
        cmd_ready  = 1'b0;
        awvalid    = 1'b0;
        arvalid    = 1'b0;
        wvalid     = 1'b0;
        wdata      = '0;
        wlast      = 1'b0;
        wd_ready   = 1'b0;
        bready     = 1'b0;
        rready     = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = '0;
        rd_last    = 1'b0;
        done_valid = 1'b0;
        done_resp  = OKAY;
        done_id    = '0;

        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0.
                cmd_ready = arst;
                if (cmd_valid) begin
                    id_d    = cmd_id;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    resp_d  = OKAY;
                    state_d = cmd_write ? WADDR : RADDR;
                end
            end

            WADDR: begin
                if (page_cross) begin
                    resp_d  = SLVERR;
                    state_d = DONE;
                end else begin
                    awvalid = 1'b1;
                    if (awready) begin
                        state_d = WDATA;
                    end
                end
            end

            WDATA: begin
                wvalid   = wd_valid;
                wdata    = wd_data;
                wd_ready = wready;
                wlast    = (cnt_q == len_q);
                if (wd_valid && wready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
                        state_d = WRESP;
                    end
                end
            end

            WRESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    if ((bid != id_q) && (bresp != DECERR)) begin
                        resp_d = SLVERR;
                    end else begin
                        resp_d = bresp;
                    end
                    state_d = DONE;
                end
            end

            RADDR: begin
                if (page_cross) begin
                    resp_d  = SLVERR;
                    state_d = DONE;
                end else begin
                    arvalid = 1'b1;
                    if (arready) begin
                        state_d = RDATA;
                    end
                end
            end

            RDATA: begin
                rd_valid = rvalid;
                rd_data  = rdata;
                rd_last  = rlast;
                rready   = rd_ready;
                if (rvalid && rd_ready) begin
                    cnt_d     = cnt_q + 8'd1;
                    beat_resp = (rid != id_q) ? worse(rresp, SLVERR) : rresp;
                    acc_resp  = worse(resp_q, beat_resp);
                    if (rlast) begin
                        // A burst that ends early or late is a slave error.
                        if (cnt_q != len_q) begin
                            acc_resp = worse(acc_resp, SLVERR);
                        end
                        state_d = DONE;
                    end
                    resp_d = acc_resp;
                end
            end

            DONE: begin
                done_valid = 1'b1;
                done_resp  = resp_q;
                done_id    = id_q;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
